// File: rtl/pwm_led_multi.sv
// Multi-channel PWM LED driver: one shared prescaled WIDTH-bit counter; each channel
// can be OFF, STATIC duty, triangle BREATHE or ON.
// Latency: pwm_out is registered, 1 clock behind cnt.
// Flow: cfg_we is always accepted, one write per cycle, with no backpressure; the write
// lands in a pending register and becomes active at the next PWM period boundary.
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   ena          run enable; low freezes counters and forces pwm_out low
//   cfg_we       config write strobe into the pending registers of cfg_ch
//   cfg_ch       target channel; values >= CHANNELS are ignored
//   cfg_mode     00 OFF, 01 STATIC, 10 BREATHE, 11 ON
//   cfg_duty     STATIC duty, or BREATHE peak level
//   prescale     counter advances every prescale+1 clocks
//   pwm_out      registered per-channel PWM outputs
//   period_tick  one-cycle pulse after each counter wrap
module pwm_led_multi #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [1:0]            cfg_mode,
  input  logic [WIDTH-1:0]      cfg_duty,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_tick
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_ON      = 2'b11
  } mode_t;

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [WIDTH-1:0]      cnt;
  logic                  tick;
  logic                  boundary;
  logic [CHANNELS-1:0]   cmp;

  // ">=" rather than "==" so that lowering prescale below the current
  // pre_cnt resynchronises on the next cycle instead of wrapping around.
  assign tick     = ena && (pre_cnt >= prescale);
  assign boundary = tick && (cnt == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= boundary;
      if (ena) begin
        pwm_out <= cmp;
        if (tick) begin
          pre_cnt <= '0;
          cnt     <= cnt + WIDTH'(1);
        end else begin
          pre_cnt <= pre_cnt + PRESCALE_W'(1);
        end
      end else begin
        pwm_out <= '0;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mode_t            pend_mode;
    mode_t            act_mode;
    logic [WIDTH-1:0] pend_duty;
    logic [WIDTH-1:0] act_duty;
    logic [WIDTH-1:0] level;
    logic             dir_up;
    logic             sel;

    // Exact decode per channel: out-of-range cfg_ch values match no channel.
    assign sel = cfg_we && (cfg_ch == CH_W'(g));

    assign cmp[g] = (act_mode == MODE_ON)
                 || ((act_mode == MODE_STATIC)  && (cnt < act_duty))
                 || ((act_mode == MODE_BREATHE) && (cnt < level));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pend_mode <= MODE_OFF;
        pend_duty <= '0;
        act_mode  <= MODE_OFF;
        act_duty  <= '0;
        level     <= '0;
        dir_up    <= 1'b1;
      end else begin
        // Same-cycle write and boundary: active takes the old pending value
        // because both reads below see pre-edge register contents.
        if (sel) begin
          pend_mode <= mode_t'(cfg_mode);
          pend_duty <= cfg_duty;
        end
        if (boundary) begin
          act_mode <= pend_mode;
          act_duty <= pend_duty;
          if (pend_mode == MODE_BREATHE) begin
            if (act_mode != MODE_BREATHE) begin
              // Entering BREATHE starts a fresh ramp from dark.
              level  <= '0;
              dir_up <= 1'b1;
            end else if (pend_duty < level) begin
              // Peak lowered below current level: clamp and head down.
              level  <= pend_duty;
              dir_up <= 1'b0;
            end else if (dir_up) begin
              // At the peak only the direction flips, so the peak is held one period.
              if (level < pend_duty) level <= level + WIDTH'(1);
              else                   dir_up <= 1'b0;
            end else begin
              if (level != '0) level <= level - WIDTH'(1);
              else             dir_up <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_led_multi.sv
module tb_pwm_led_multi;

  localparam int NCH = 5;  // non power of two so cfg_ch can carry invalid channels

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ena;
  logic           cfg_we;
  logic [2:0]     cfg_ch;
  logic [1:0]     cfg_mode;
  logic [7:0]     cfg_duty;
  logic [7:0]     prescale;
  logic [NCH-1:0] pwm_out;
  logic           period_tick;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  pwm_led_multi #(.CHANNELS(NCH), .WIDTH(8), .PRESCALE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .prescale(prescale),
    .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Reference model state (plain integers; modes 0 OFF,1 STATIC,2 BREATHE,3 ON)
  int             m_pre, m_cnt;
  int             m_pm[NCH], m_pd[NCH], m_am[NCH], m_ad[NCH], m_lvl[NCH];
  bit             m_up[NCH];
  logic [NCH-1:0] m_out;
  bit             m_pt;

  typedef struct {
    bit         en;
    logic [2:0] ch;
    logic [1:0] mode;
    logic [7:0] duty;
  } wr_t;

  wr_t wq[$];
  wr_t fin;
  int  hi[NCH];
  int  rise[NCH];
  int  win_len;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_step();
    bit             tk;
    bit             bnd;
    int             old;
    logic [NCH-1:0] nout;
    if (!rst_n) begin
      m_pre = 0; m_cnt = 0; m_out = '0; m_pt = 0;
      for (int c = 0; c < NCH; c++) begin
        m_pm[c] = 0; m_pd[c] = 0; m_am[c] = 0; m_ad[c] = 0; m_lvl[c] = 0; m_up[c] = 1;
      end
      return;
    end
    tk   = ena && (m_pre >= int'(prescale));
    bnd  = tk && (m_cnt == 255);
    nout = '0;
    for (int c = 0; c < NCH; c++) begin
      case (m_am[c])
        1:       nout[c] = (m_cnt < m_ad[c]);
        2:       nout[c] = (m_cnt < m_lvl[c]);
        3:       nout[c] = 1'b1;
        default: nout[c] = 1'b0;
      endcase
    end
    m_out = ena ? nout : '0;
    m_pt  = bnd;
    if (tk) begin
      m_pre = 0;
      m_cnt = (m_cnt + 1) % 256;
    end else if (ena) begin
      m_pre++;
    end
    if (bnd) begin
      for (int c = 0; c < NCH; c++) begin
        old     = m_am[c];
        m_am[c] = m_pm[c];
        m_ad[c] = m_pd[c];
        if (m_am[c] == 2) begin
          if (old != 2) begin
            m_lvl[c] = 0; m_up[c] = 1;
          end else if (m_ad[c] < m_lvl[c]) begin
            m_lvl[c] = m_ad[c]; m_up[c] = 0;
          end else if (m_up[c]) begin
            if (m_lvl[c] < m_ad[c]) m_lvl[c]++;
            else                    m_up[c] = 0;
          end else begin
            if (m_lvl[c] > 0) m_lvl[c]--;
            else              m_up[c] = 1;
          end
        end
      end
    end
    if (cfg_we && int'(cfg_ch) < NCH) begin
      m_pm[cfg_ch] = int'(cfg_mode);
      m_pd[cfg_ch] = int'(cfg_duty);
    end
  endfunction

  // One clock: model advances with the inputs present at the edge, outputs compared 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("pwm_out", 32'(pwm_out), 32'(m_out));
    chk("period_tick", 32'(period_tick), 32'(m_pt));
  endtask

  task automatic wr(input logic [2:0] ch, input logic [1:0] mode, input logic [7:0] duty);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_duty = duty;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic wait_ptick(input int bound);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!m_pt && n < bound);
    chk("wait_ptick", 32'(m_pt), 32'd1);
  endtask

  // From a period_tick sample, run one full period (through the next period_tick
  // sample), issuing queued writes from index 10 and an optional write landing on
  // the closing boundary edge. Collects per-channel high counts and rising edges.
  task automatic run_period();
    logic [NCH-1:0] prev;
    bit             done;
    wr_t            w;
    prev    = pwm_out;
    done    = 0;
    win_len = 0;
    for (int c = 0; c < NCH; c++) begin hi[c] = 0; rise[c] = 0; end
    while (!done && win_len < 5000) begin
      if (wq.size() > 0 && win_len >= 10) begin
        w = wq.pop_front();
        cfg_we = 1'b1; cfg_ch = w.ch; cfg_mode = w.mode; cfg_duty = w.duty;
      end else if (fin.en && ena && m_cnt == 255 && m_pre >= int'(prescale)) begin
        cfg_we = 1'b1; cfg_ch = fin.ch; cfg_mode = fin.mode; cfg_duty = fin.duty;
        fin.en = 1'b0;
      end
      cycle();
      cfg_we = 1'b0;
      win_len++;
      for (int c = 0; c < NCH; c++) begin
        hi[c]   += int'(pwm_out[c]);
        rise[c] += int'(pwm_out[c] & ~prev[c]);
      end
      prev = pwm_out;
      if (m_pt) done = 1;
    end
    chk("period_end", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int r;
    int breathe_exp[10];
    breathe_exp = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
    rst_n = 1'b0; ena = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_duty = '0; prescale = '0; fin = '{1'b0, 3'd0, 2'd0, 8'd0};

    // Reset state
    repeat (3) cycle();
    chk("reset_pwm", 32'(pwm_out), 32'd0);
    chk("reset_ptick", 32'(period_tick), 32'd0);

    // ch0 STATIC 64 at prescale 0
    rst_n = 1'b1; ena = 1'b1; prescale = 8'd0;
    wr(3'd0, 2'd1, 8'd64);
    wait_ptick(400);
    run_period();
    chk("p0_len", 32'(win_len), 32'd256);
    chk("p0_ch0_hi", 32'(hi[0]), 32'd64);
    chk("p0_others_hi", 32'(hi[1] + hi[2] + hi[3] + hi[4]), 32'd0);

    // prescale 3, ch1 STATIC 128
    prescale = 8'd3;
    wr(3'd1, 2'd1, 8'd128);
    wait_ptick(2000);
    run_period();
    chk("ps3_len", 32'(win_len), 32'd1024);
    chk("ps3_ch1_hi", 32'(hi[1]), 32'd512);
    chk("ps3_ch1_runs", 32'(rise[1]), 32'd1);
    chk("ps3_ch0_hi", 32'(hi[0]), 32'd256);

    // ch2 BREATHE peak 3
    prescale = 8'd0;
    wr(3'd2, 2'd2, 8'd3);
    wait_ptick(2000);
    for (int i = 0; i < 10; i++) begin
      run_period();
      chk($sformatf("breathe_lvl%0d", i), 32'(hi[2]), 32'(breathe_exp[i]));
    end

    // ch0 duty rewrite: mid-period 200, then 30 coincident with the boundary
    wq.push_back('{1'b1, 3'd0, 2'd1, 8'd200});
    fin = '{1'b1, 3'd0, 2'd1, 8'd30};
    run_period();
    chk("rw_cur_hi", 32'(hi[0]), 32'd64);
    chk("rw_cur_runs", 32'(rise[0]), 32'd1);
    run_period();
    chk("rw_next_hi", 32'(hi[0]), 32'd200);
    chk("rw_next_runs", 32'(rise[0]), 32'd1);
    run_period();
    chk("rw_bnd_hi", 32'(hi[0]), 32'd30);

    // Freeze at cnt=100 for 50 clocks
    n = 0;
    do begin cycle(); n++; end while (m_cnt != 100 && n < 300);
    ena = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      chk("frz_pwm", 32'(pwm_out), 32'd0);
      chk("frz_ptick", 32'(period_tick), 32'd0);
    end
    ena = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (period_tick !== 1'b1 && n < 400);
    chk("resume_to_ptick", 32'(n), 32'd156);

    // ch3 ON, then OFF together with writes to nonexistent channels
    wr(3'd3, 2'd3, 8'd0);
    wait_ptick(400);
    run_period();
    chk("on_ch3_hi", 32'(hi[3]), 32'd256);
    wq.push_back('{1'b1, 3'd3, 2'd0, 8'd0});
    wq.push_back('{1'b1, 3'd5, 2'd3, 8'd255});
    wq.push_back('{1'b1, 3'd6, 2'd3, 8'd255});
    wq.push_back('{1'b1, 3'd7, 2'd2, 8'd9});
    run_period();
    chk("off_pend_ch3_hi", 32'(hi[3]), 32'd256);
    run_period();
    chk("off_ch3_hi", 32'(hi[3]), 32'd0);
    chk("inv_ch4_hi", 32'(hi[4]), 32'd0);
    chk("inv_ch0_hi", 32'(hi[0]), 32'd30);
    chk("inv_ch1_hi", 32'(hi[1]), 32'd128);

    // Reset mid-operation discards a pending write
    wr(3'd0, 2'd3, 8'd0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    wait_ptick(400);
    run_period();
    chk("rst_pend_len", 32'(win_len), 32'd256);
    chk("rst_pend_hi", 32'(hi[0] + hi[1] + hi[2] + hi[3] + hi[4]), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 20000; i++) begin
      r        = int'($urandom_range(0, 999));
      cfg_we   = (r < 30);
      cfg_ch   = 3'($urandom_range(0, 7));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_duty = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      if (!ena && r > 950)      ena = 1'b1;
      else if (ena && r > 996)  ena = 1'b0;
      if (r == 500) prescale = 8'($urandom_range(0, 3));
      rst_n = !(r == 777 && $urandom_range(0, 3) == 0);
      cycle();
    end
    cfg_we = 1'b0;
    rst_n  = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
